hcu_grid_sched: RTL and testbench
=================================

Name: hcu_grid_sched

Overview:
Sequences the histogram unit (HCU) over the GRID_X x GRID_Y cell grid of one LBP image. Runs after the CLBP stage reports completion.
- Issues one HCU start per cell, in row-major order.
- Supplies each cell's grid coordinates, LBP-RAM base address and histogram-RAM base address.
- Hands the shared RAMs between CLBP, HCU and comparator.
- In recognition mode, launches the comparator after the last cell; reports a single completion pulse per image.

Parameters:
GRID_X, 4, cells per row (1..16)
GRID_Y, 4, cell rows (1..16)
CELL_W, 16, cell width in pixels
CELL_H, 16, cell height in pixels
IMG_W, 64, image width in pixels
BINS, 256, histogram bins per cell
ADDR_W, 12, LBP RAM address width
HADDR_W, 12, histogram RAM address width
WDOG_CYCLES, 1024, watchdog limit (used only with SCHED_WDOG_EN)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  pulse, CLBP image finished
mode  in  1  0 = enroll, 1 = recognize
hcu_start  out  1  one-cycle pulse, HCU processes current cell
hcu_finish  in  1  pulse, HCU cell done
gridX_o  out  4  current cell column
gridY_o  out  4  current cell row
cell_base_o  out  ADDR_W  LBP RAM address of cell top-left pixel
hist_base_o  out  HADDR_W  histogram RAM base for current cell
cell_idx_o  out  8  linear cell index
comparator_enable  out  1  one-cycle pulse, start comparator
comparator_finish  in  1  pulse, comparator done
ram_sel  out  2  RAM owner: 0 CLBP, 1 HCU, 2 comparator
busy  out  1  walk in progress
done  out  1  one-cycle pulse, image fully processed
error  out  1  watchdog expiry flag, sticky

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: all outputs 0, ram_sel = 0, FSM in IDLE, counters 0.
- Reset mid-operation: rst aborts any state on the next edge; no pulse is emitted.
- All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT, COMP, COMP_WAIT, DONE.
- IDLE:
  - ram_sel = 0, busy = 0.
  - On start: latch mode, clear counters and address registers, go to ISSUE.
  - In the cycle the FSM is in ISSUE: busy = 1, ram_sel = 1.
- ISSUE: hcu_start = 1 for exactly this cycle, then go to WAIT.
- WAIT:
  - hcu_finish is sampled only in WAIT; it is ignored in every other state.
  - On hcu_finish with cells remaining: advance to the next cell, go to ISSUE. Next hcu_start comes 1 cycle after hcu_finish.
  - On hcu_finish for the last cell (GRID_X-1, GRID_Y-1): latched mode 0 → DONE; mode 1 → COMP.
- Cell advance:
  - gridX_o increments; at GRID_X-1 it wraps to 0 and gridY_o increments.
  - cell_idx_o increments by 1.
  - hist_base_o increases by BINS.
  - cell_base_o = gridY*CELL_H*IMG_W + gridX*CELL_W, updated incrementally: +CELL_W within a row; +CELL_H*IMG_W - (GRID_X-1)*CELL_W on row wrap.
  - All address arithmetic wraps modulo 2^ADDR_W / 2^HADDR_W.
- Output stability: gridX_o, gridY_o, cell_base_o, hist_base_o and cell_idx_o are stable from ISSUE through WAIT.
- COMP: comparator_enable = 1 for one cycle, ram_sel = 2, go to COMP_WAIT.
- COMP_WAIT: ram_sel = 2; on comparator_finish go to DONE.
- DONE: done = 1 for one cycle, busy = 0, ram_sel = 0, go to IDLE.
- start while busy: ignored. mode changes after start: ignored.
- Simultaneous start and rst: rst wins.

Optional Feature:
SCHED_WDOG_EN
- Defined:
  - A counter runs in WAIT and COMP_WAIT and clears on every state entry.
  - If it reaches WDOG_CYCLES, error is set, the FSM goes to DONE and done pulses.
  - error stays set until the next accepted start or rst.
- Undefined: error is tied to 0 and the FSM waits indefinitely.

Decomposition:
- Shared package holds:
  - FSM state encoding;
  - RAM_SEL_CLBP = 0, RAM_SEL_HCU = 1, RAM_SEL_COMP = 2;
  - the MODE_ENROLL / MODE_RECOG constants.
- One sub-module, grid_addr_gen, owns the grid counters and incremental address registers, with inputs clear, advance and last.

Test Plan:
- Reset: hold rst 3 cycles mid-run → all outputs 0, ram_sel = 0, busy = 0 on the first edge.
- Enroll walk: mode = 0, start, hcu_finish 5 cycles after each hcu_start.
  - 16 hcu_start pulses with (gridX,gridY) = (0,0),(1,0)..(3,3).
  - Cell 5 (1,1): cell_base_o = 1040, hist_base_o = 1280.
  - Cell 15: cell_base_o = 3120, hist_base_o = 3840.
  - done 1 cycle after the 16th hcu_finish; comparator_enable never asserted.
- Recognize walk: mode = 1, same stimulus.
  - comparator_enable pulses 1 cycle after the 16th hcu_finish; ram_sel = 2 until done.
  - comparator_finish 10 cycles later → done on the next cycle, ram_sel = 0.
- Ignored inputs: pulse start and toggle mode at cell 3 → the walk is unaffected and the latched mode is used. A stray hcu_finish in ISSUE or IDLE → no advance.
- Abort and restart: rst during WAIT of cell 7, then start → first hcu_start shows (0,0), cell_base_o = 0.
- Watchdog (SCHED_WDOG_EN, WDOG_CYCLES = 32): withhold hcu_finish on cell 2 → error = 1 and a done pulse 32 cycles after WAIT entry; next start clears error.

Source files
------------

// File: rtl/hcu_grid_sched_pkg.sv
// hcu_grid_sched_pkg: shared definitions for the HCU grid scheduler.
//   sched_state_e  - scheduler FSM state encoding
//   RAM_SEL_*      - ram_sel owner codes (CLBP / HCU / comparator)
//   MODE_*         - image mode values sampled on start
package hcu_grid_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_WAIT      = 3'd2,
        S_COMP      = 3'd3,
        S_COMP_WAIT = 3'd4,
        S_DONE      = 3'd5
    } sched_state_e;

    localparam logic [1:0] RAM_SEL_CLBP = 2'd0;
    localparam logic [1:0] RAM_SEL_HCU  = 2'd1;
    localparam logic [1:0] RAM_SEL_COMP = 2'd2;

    localparam logic MODE_ENROLL = 1'b0;
    localparam logic MODE_RECOG  = 1'b1;

endpackage

// File: rtl/hcu_grid_sched_if.sv
// hcu_grid_sched_if: scheduler <-> HCU / comparator handshake and cell info.
//   master: scheduler side (drives hcu_start, cell coordinates/addresses,
//           comparator_enable; receives hcu_finish, comparator_finish)
//   slave : HCU / comparator side
interface hcu_grid_sched_if #(
    parameter int ADDR_W  = 12,
    parameter int HADDR_W = 12
);
    logic               hcu_start;
    logic               hcu_finish;
    logic [3:0]         gridX_o;
    logic [3:0]         gridY_o;
    logic [ADDR_W-1:0]  cell_base_o;
    logic [HADDR_W-1:0] hist_base_o;
    logic [7:0]         cell_idx_o;
    logic               comparator_enable;
    logic               comparator_finish;

    modport master (
        output hcu_start, gridX_o, gridY_o, cell_base_o, hist_base_o,
               cell_idx_o, comparator_enable,
        input  hcu_finish, comparator_finish
    );

    modport slave (
        input  hcu_start, gridX_o, gridY_o, cell_base_o, hist_base_o,
               cell_idx_o, comparator_enable,
        output hcu_finish, comparator_finish
    );
endinterface

// File: rtl/hcu_grid_sched_grid_addr_gen.sv
// grid_addr_gen: grid counters and incremental cell / histogram addresses.
//   clk, rst   - clock, synchronous active-high reset
//   clear      - return to cell (0,0), all addresses 0
//   advance    - step to the next cell in row-major order
//   last_o     - current cell is (GRID_X-1, GRID_Y-1)
//   gridx_o/gridy_o, cell_base_o, hist_base_o, cell_idx_o - current cell
module grid_addr_gen
    import hcu_grid_sched_pkg::*;
#(
    parameter int GRID_X  = 4,
    parameter int GRID_Y  = 4,
    parameter int CELL_W  = 16,
    parameter int CELL_H  = 16,
    parameter int IMG_W   = 64,
    parameter int BINS    = 256,
    parameter int ADDR_W  = 12,
    parameter int HADDR_W = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               advance,
    output logic               last_o,
    output logic [3:0]         gridx_o,
    output logic [3:0]         gridy_o,
    output logic [ADDR_W-1:0]  cell_base_o,
    output logic [HADDR_W-1:0] hist_base_o,
    output logic [7:0]         cell_idx_o
);
    // Row wrap: drop down CELL_H pixel rows and back to column 0. Any
    // negative intermediate folds into the modulo-2^ADDR_W arithmetic.
    localparam logic [ADDR_W-1:0]  COL_STEP  = ADDR_W'(CELL_W);
    localparam logic [ADDR_W-1:0]  ROW_STEP  = ADDR_W'(CELL_H*IMG_W - (GRID_X-1)*CELL_W);
    localparam logic [HADDR_W-1:0] HIST_STEP = HADDR_W'(BINS);
    localparam logic [3:0]         X_LAST    = 4'(GRID_X-1);
    localparam logic [3:0]         Y_LAST    = 4'(GRID_Y-1);

    logic [3:0]         gx_q, gx_d, gy_q, gy_d;
    logic [ADDR_W-1:0]  base_q, base_d;
    logic [HADDR_W-1:0] hist_q, hist_d;
    logic [7:0]         idx_q, idx_d;
    logic               row_end;

    assign row_end = (gx_q == X_LAST);
    assign last_o  = row_end && (gy_q == Y_LAST);

    always_comb begin
        gx_d   = gx_q;
        gy_d   = gy_q;
        base_d = base_q;
        hist_d = hist_q;
        idx_d  = idx_q;
        if (clear) begin
            gx_d   = '0;
            gy_d   = '0;
            base_d = '0;
            hist_d = '0;
            idx_d  = '0;
        end else if (advance) begin
            idx_d  = idx_q + 8'd1;
            hist_d = hist_q + HIST_STEP;
            if (row_end) begin
                gx_d   = '0;
                gy_d   = gy_q + 4'd1;
                base_d = base_q + ROW_STEP;
            end else begin
                gx_d   = gx_q + 4'd1;
                base_d = base_q + COL_STEP;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gx_q   <= '0;
            gy_q   <= '0;
            base_q <= '0;
            hist_q <= '0;
            idx_q  <= '0;
        end else begin
            gx_q   <= gx_d;
            gy_q   <= gy_d;
            base_q <= base_d;
            hist_q <= hist_d;
            idx_q  <= idx_d;
        end
    end

    assign gridx_o     = gx_q;
    assign gridy_o     = gy_q;
    assign cell_base_o = base_q;
    assign hist_base_o = hist_q;
    assign cell_idx_o  = idx_q;
endmodule

// File: rtl/hcu_grid_sched.sv
// hcu_grid_sched: walks the HCU over the GRID_X x GRID_Y cells of one image,
// then optionally runs the comparator and pulses done.
//   clk, rst  - clock, synchronous active-high reset
//   start     - CLBP image finished (accepted only in IDLE)
//   mode      - 0 enroll, 1 recognize (latched on accepted start)
//   hcu       - master side of hcu_grid_sched_if (HCU/comparator handshake)
//   ram_sel   - shared RAM owner (0 CLBP, 1 HCU, 2 comparator)
//   busy      - walk in progress
//   done      - one-cycle pulse per image
//   error     - sticky watchdog expiry
// Optional: define SCHED_WDOG_EN to enable the WAIT / COMP_WAIT watchdog
// (WDOG_CYCLES parameter); otherwise error is 0 and waits are unbounded.
module hcu_grid_sched
    import hcu_grid_sched_pkg::*;
#(
    parameter int GRID_X  = 4,
    parameter int GRID_Y  = 4,
    parameter int CELL_W  = 16,
    parameter int CELL_H  = 16,
    parameter int IMG_W   = 64,
    parameter int BINS    = 256,
    parameter int ADDR_W  = 12,
    parameter int HADDR_W = 12
`ifdef SCHED_WDOG_EN
    ,
    parameter int WDOG_CYCLES = 1024
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    hcu_grid_sched_if.master hcu,
    output logic [1:0]       ram_sel,
    output logic             busy,
    output logic             done,
    output logic             error
);
    sched_state_e state_q, state_d;
    logic         mode_q, mode_d;
    logic         clear, advance, last;
    logic         hcu_start_q, comp_en_q, busy_q, done_q;
    logic [1:0]   ram_sel_q;

    logic [3:0]         gx, gy;
    logic [ADDR_W-1:0]  cell_base;
    logic [HADDR_W-1:0] hist_base;
    logic [7:0]         cell_idx;

`ifdef SCHED_WDOG_EN
    localparam int WDW = $clog2(WDOG_CYCLES + 1);
    logic [WDW-1:0] wdog_q, wdog_d;
    logic           wdog_hit;
    logic           error_q;
`endif

    grid_addr_gen #(
        .GRID_X(GRID_X), .GRID_Y(GRID_Y), .CELL_W(CELL_W), .CELL_H(CELL_H),
        .IMG_W(IMG_W), .BINS(BINS), .ADDR_W(ADDR_W), .HADDR_W(HADDR_W)
    ) u_addr (
        .clk(clk), .rst(rst), .clear(clear), .advance(advance), .last_o(last),
        .gridx_o(gx), .gridy_o(gy), .cell_base_o(cell_base),
        .hist_base_o(hist_base), .cell_idx_o(cell_idx)
    );

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        clear   = 1'b0;
        advance = 1'b0;
        unique case (state_q)
            S_IDLE: if (start) begin
                state_d = S_ISSUE;
                mode_d  = mode;
                clear   = 1'b1;
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: if (hcu.hcu_finish) begin
                if (last) begin
                    state_d = (mode_q == MODE_RECOG) ? S_COMP : S_DONE;
                end else begin
                    advance = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_COMP:      state_d = S_COMP_WAIT;
            S_COMP_WAIT: if (hcu.comparator_finish) state_d = S_DONE;
            S_DONE:      state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
`ifdef SCHED_WDOG_EN
        // Expiry only overrides a wait that is still stuck this cycle.
        wdog_hit = 1'b0;
        if ((state_q == S_WAIT || state_q == S_COMP_WAIT) && state_d == state_q
            && wdog_q == WDW'(WDOG_CYCLES - 1)) begin
            wdog_hit = 1'b1;
            state_d  = S_DONE;
        end
        if (state_d != state_q)
            wdog_d = '0;
        else if (state_q == S_WAIT || state_q == S_COMP_WAIT)
            wdog_d = wdog_q + WDW'(1);
        else
            wdog_d = '0;
`endif
    end

    // Outputs are decoded from the next state so they are registered yet
    // line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            mode_q      <= MODE_ENROLL;
            hcu_start_q <= 1'b0;
            comp_en_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ram_sel_q   <= RAM_SEL_CLBP;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            hcu_start_q <= (state_d == S_ISSUE);
            comp_en_q   <= (state_d == S_COMP);
            done_q      <= (state_d == S_DONE);
            busy_q      <= (state_d == S_ISSUE) || (state_d == S_WAIT) ||
                           (state_d == S_COMP)  || (state_d == S_COMP_WAIT);
            if (state_d == S_ISSUE || state_d == S_WAIT)
                ram_sel_q <= RAM_SEL_HCU;
            else if (state_d == S_COMP || state_d == S_COMP_WAIT)
                ram_sel_q <= RAM_SEL_COMP;
            else
                ram_sel_q <= RAM_SEL_CLBP;
        end
    end

`ifdef SCHED_WDOG_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_q  <= '0;
            error_q <= 1'b0;
        end else begin
            wdog_q <= wdog_d;
            if (state_q == S_IDLE && start)
                error_q <= 1'b0;
            else if (wdog_hit)
                error_q <= 1'b1;
        end
    end
    assign error = error_q;
`else
    assign error = 1'b0;
`endif

    assign hcu.hcu_start         = hcu_start_q;
    assign hcu.comparator_enable = comp_en_q;
    assign hcu.gridX_o           = gx;
    assign hcu.gridY_o           = gy;
    assign hcu.cell_base_o       = cell_base;
    assign hcu.hist_base_o       = hist_base;
    assign hcu.cell_idx_o        = cell_idx;
    assign ram_sel               = ram_sel_q;
    assign busy                  = busy_q;
    assign done                  = done_q;
endmodule

// File: tb/tb_hcu_grid_sched.sv
// tb_hcu_grid_sched: directed bench for hcu_grid_sched (4x4 grid, 16x16
// cells, 64-pixel image, 256 bins). Outputs sampled on the falling edge.
// Define SCHED_WDOG_EN to also exercise the watchdog (WDOG_CYCLES = 32).
module tb_hcu_grid_sched;
    logic       clk = 1'b0;
    logic       rst, start, mode;
    logic [1:0] ram_sel;
    logic       busy, done, error;
    int         nvec = 0;
    int         nmis = 0;
    int         hs_cnt = 0;
    int         cmp_cnt = 0;

    hcu_grid_sched_if #(.ADDR_W(12), .HADDR_W(12)) hcu_if ();

    hcu_grid_sched #(
        .GRID_X(4), .GRID_Y(4), .CELL_W(16), .CELL_H(16), .IMG_W(64),
        .BINS(256), .ADDR_W(12), .HADDR_W(12)
`ifdef SCHED_WDOG_EN
        , .WDOG_CYCLES(32)
`endif
    ) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .hcu(hcu_if),
        .ram_sel(ram_sel), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (hcu_if.hcu_start)         hs_cnt++;
        if (hcu_if.comparator_enable) cmp_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, " hcu_start"}, hcu_if.hcu_start, 0);
        chk({tag, " gridX"}, hcu_if.gridX_o, 0);
        chk({tag, " gridY"}, hcu_if.gridY_o, 0);
        chk({tag, " cell_base"}, hcu_if.cell_base_o, 0);
        chk({tag, " hist_base"}, hcu_if.hist_base_o, 0);
        chk({tag, " cell_idx"}, hcu_if.cell_idx_o, 0);
        chk({tag, " comp_en"}, hcu_if.comparator_enable, 0);
        chk({tag, " ram_sel"}, ram_sel, 0);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " done"}, done, 0);
        chk({tag, " error"}, error, 0);
    endtask

    // One image walk; hcu_finish lands 5 cycles after each hcu_start.
    // poke: at cell 3 pulse start, flip mode and drive a stray hcu_finish
    // during ISSUE. abort_at >= 0 returns in WAIT of that cell.
    task automatic walk(input logic m, input bit poke, input int abort_at);
        int hs0, cc0;
        hs0 = hs_cnt;
        cc0 = cmp_cnt;
        start = 1'b1;
        mode  = m;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 16; c++) begin
            chk("hcu_start", hcu_if.hcu_start, 1);
            chk("gridX", hcu_if.gridX_o, c % 4);
            chk("gridY", hcu_if.gridY_o, c / 4);
            chk("cell_idx", hcu_if.cell_idx_o, c);
            chk("cell_base", hcu_if.cell_base_o, (c / 4) * 1024 + (c % 4) * 16);
            chk("hist_base", hcu_if.hist_base_o, c * 256);
            chk("ram_sel_hcu", ram_sel, 1);
            chk("busy", busy, 1);
            if (c == 5) begin
                chk("cell5_base", hcu_if.cell_base_o, 1040);
                chk("cell5_hist", hcu_if.hist_base_o, 1280);
            end
            if (c == 15) begin
                chk("cell15_base", hcu_if.cell_base_o, 3120);
                chk("cell15_hist", hcu_if.hist_base_o, 3840);
            end
            if (poke && c == 3) begin
                start             = 1'b1;
                mode              = ~m;
                hcu_if.hcu_finish = 1'b1;
            end
            @(negedge clk);
            start             = 1'b0;
            hcu_if.hcu_finish = 1'b0;
            chk("hcu_start_1cyc", hcu_if.hcu_start, 0);
            chk("cell_idx_wait", hcu_if.cell_idx_o, c);
            if (c == abort_at) return;
            repeat (3) @(negedge clk);
            chk("gridX_stable", hcu_if.gridX_o, c % 4);
            chk("hcu_start_low", hcu_if.hcu_start, 0);
            hcu_if.hcu_finish = 1'b1;
            @(negedge clk);
            hcu_if.hcu_finish = 1'b0;
        end
        if (m == 1'b0) begin
            chk("enr_done", done, 1);
            chk("enr_busy", busy, 0);
            chk("enr_ram_sel", ram_sel, 0);
        end else begin
            chk("rec_comp_en", hcu_if.comparator_enable, 1);
            chk("rec_ram_sel", ram_sel, 2);
            chk("rec_done_early", done, 0);
            for (int k = 0; k < 9; k++) begin
                @(negedge clk);
                chk("rec_ram_sel_wait", ram_sel, 2);
                chk("rec_comp_en_1cyc", hcu_if.comparator_enable, 0);
            end
            hcu_if.comparator_finish = 1'b1;
            @(negedge clk);
            hcu_if.comparator_finish = 1'b0;
            chk("rec_done", done, 1);
            chk("rec_ram_sel_done", ram_sel, 0);
            chk("rec_busy_done", busy, 0);
        end
        @(negedge clk);
        chk("done_1cyc", done, 0);
        chk("hcu_start_pulses", hs_cnt - hs0, 16);
        chk("comp_en_pulses", cmp_cnt - cc0, (m == 1'b1) ? 1 : 0);
    endtask

    initial begin
        #200000;
        $display("FAIL sim_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; mode = 1'b0;
        hcu_if.hcu_finish = 1'b0;
        hcu_if.comparator_finish = 1'b0;
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        rst = 1'b0;

        // Stray hcu_finish in IDLE must not start or advance anything.
        hcu_if.hcu_finish = 1'b1;
        @(negedge clk);
        hcu_if.hcu_finish = 1'b0;
        @(negedge clk);
        chk_idle_outputs("idle_stray");

        walk(1'b0, 1'b0, -1);
        walk(1'b1, 1'b0, -1);
        walk(1'b0, 1'b1, -1);
        walk(1'b1, 1'b1, -1);

        // Abort in WAIT of cell 7; start together with rst must lose.
        walk(1'b0, 1'b0, 7);
        rst = 1'b1;
        @(negedge clk);
        chk_idle_outputs("abort");
        start = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_wins_busy", busy, 0);
        chk("rst_wins_hcu_start", hcu_if.hcu_start, 0);
        rst = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("post_rst_idle", busy, 0);
        walk(1'b0, 1'b0, -1);

`ifdef SCHED_WDOG_EN
        // Cell 2 never finishes: expiry 32 cycles after WAIT entry.
        walk(1'b0, 1'b0, 2);
        repeat (31) @(negedge clk);
        chk("wdog_done_early", done, 0);
        chk("wdog_err_early", error, 0);
        @(negedge clk);
        chk("wdog_done", done, 1);
        chk("wdog_error", error, 1);
        chk("wdog_busy", busy, 0);
        @(negedge clk);
        chk("wdog_error_sticky", error, 1);
        chk("wdog_done_1cyc", done, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("wdog_error_clear", error, 0);
        chk("wdog_restart", hcu_if.hcu_start, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
`endif
        chk("error_final", error, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
